// File: rtl/output_pulse_driver.sv
// rtl/output_pulse_driver.sv - programmable pulse-train driver for one output pin
// Emits N pulses of A active clocks separated by I inactive clocks, with start/stop/busy/done handshake.
module output_pulse_driver #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 output_valid_level,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CNT_WIDTH-1:0] active_clk,
   input  logic [CNT_WIDTH-1:0] idle_clk,
   input  logic [CNT_WIDTH-1:0] pulse_num,
   output logic                 output_signal,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] pulse_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b001,
      S_ACTIVE = 3'b010,
      S_GAP    = 3'b100
   } state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] phase_q, phase_d;
   logic [CNT_WIDTH-1:0] act_len_q, act_len_d;
   logic [CNT_WIDTH-1:0] idle_len_q, idle_len_d;
   logic [CNT_WIDTH-1:0] num_q, num_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 out_q, out_d;

   logic                 accept;
   logic                 act_end;
   logic                 gap_end;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 last_pulse;

   assign accept     = start && !stop && (pulse_num != '0);
   assign act_end    = (phase_q == act_len_q - ONE);
   assign gap_end    = (phase_q == idle_len_q - ONE);
   assign cnt_inc    = cnt_q + ONE;
   assign last_pulse = (cnt_inc == num_q);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (accept) state_d = S_ACTIVE;
         S_ACTIVE: begin
            if (stop)                    state_d = S_IDLE;
            else if (act_end)            state_d = last_pulse ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (stop)                    state_d = S_IDLE;
            else if (gap_end)            state_d = S_ACTIVE;
         end
         default:                        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      phase_d    = phase_q;
      act_len_d  = act_len_q;
      idle_len_d = idle_len_q;
      num_d      = num_q;
      cnt_d      = cnt_q;
      busy_d     = (state_d != S_IDLE);
      done_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               cnt_d = '0;
               if (pulse_num != '0) begin
                  act_len_d  = (active_clk == '0) ? ONE : active_clk;
                  idle_len_d = (idle_clk == '0) ? ONE : idle_clk;
                  num_d      = pulse_num;
                  phase_d    = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ACTIVE: begin
            if (!stop) begin
               if (act_end) begin
                  cnt_d   = cnt_inc;
                  done_d  = last_pulse;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + ONE;
               end
            end
         end
         S_GAP: begin
            if (!stop) phase_d = gap_end ? '0 : phase_q + ONE;
         end
         default: ;
      endcase
      // Level is sampled every cycle so a polarity change reaches the pin one clock later in any state.
      out_d = (state_d == S_ACTIVE) ? output_valid_level : ~output_valid_level;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase_q    <= '0;
         act_len_q  <= '0;
         idle_len_q <= '0;
         num_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         out_q      <= ~output_valid_level;
      end else begin
         phase_q    <= phase_d;
         act_len_q  <= act_len_d;
         idle_len_q <= idle_len_d;
         num_q      <= num_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         out_q      <= out_d;
      end
   end

   assign output_signal = out_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pulse_cnt     = cnt_q;

endmodule

// File: doc/output_pulse_driver.md
# output_pulse_driver

Drives one digital output line (valve, LED, step/enable line) with a programmable train of pulses at a selectable active level. This is the output-side counterpart of the sensor input debounce path: the sensor path turns a noisy line into a clean, level-normalised status, and this block turns a clean command into an exactly-timed line waveform. It sits between the command/register logic and the FPGA output pin. A start/stop/busy/done handshake lets control logic run a pulse burst and wait for it to finish.

## Interface
- CNT_WIDTH, 32, width of the timing and pulse counters and of the configuration inputs
- sys_clk  input  1  system clock; all logic on the rising edge
- sys_rst_n  input  1  asynchronous reset, active low
- output_valid_level  input  1  line level meaning "active" (1 = high-active, 0 = low-active)
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- stop  input  1  abort request; sampled every cycle
- active_clk  input  CNT_WIDTH  active-phase length in clocks; 0 is treated as 1
- idle_clk  input  CNT_WIDTH  inactive gap between pulses in clocks; 0 is treated as 1
- pulse_num  input  CNT_WIDTH  number of pulses in the burst
- output_signal  output  1  registered drive to the pin
- busy  output  1  high while a burst is running
- done  output  1  one-cycle pulse when a burst completes normally
- pulse_cnt  output  CNT_WIDTH  pulses completed in the current or last burst

## Operation
- Reset: state IDLE; output_signal = ~output_valid_level; busy = 0; done = 0; pulse_cnt = 0; internal counters = 0.
- States are IDLE, ACTIVE and GAP. The one-hot encoding is 3'b001, 3'b010 and 3'b100.
- output_signal is registered every cycle. Its next value is output_valid_level in ACTIVE and ~output_valid_level in every other state. A change of output_valid_level therefore reaches the pin one cycle later, in any state.
- IDLE, behaviour when start=1 and stop=0:
  - If pulse_num != 0: latch active_clk, idle_clk and pulse_num (applying the zero-to-1 rule); clear pulse_cnt and the phase counter; go to ACTIVE; set busy = 1.
  - If pulse_num == 0: stay in IDLE; done = 1 for one cycle; clear pulse_cnt; no line activity.
- ACTIVE:
  - The phase counter runs from 0 to A-1, where A is the latched active length.
  - At count A-1, pulse_cnt increments.
  - If the new pulse_cnt equals the latched pulse_num: go to IDLE, busy = 0, done = 1 for one cycle.
  - Otherwise: go to GAP and clear the phase counter.
- GAP: the phase counter runs from 0 to I-1, where I is the latched idle length. At count I-1, go to ACTIVE and clear the counter.
- stop=1 in ACTIVE or GAP:
  - Go to IDLE on the next cycle; busy = 0; done stays 0.
  - The line is inactive on the next cycle.
  - pulse_cnt keeps the number of fully completed pulses; a truncated pulse is not counted.
- stop has priority over start in the same cycle. In IDLE, start=1 together with stop=1 does nothing.
- start while busy is ignored. Configuration inputs changing while busy have no effect until the next accepted start.
- pulse_cnt never exceeds the latched pulse_num, so it cannot wrap. The phase counters compare with ==, and latched lengths are at least 1.

## Timing
- Start is accepted at edge T:
  - busy = 1 from T+1.
  - output_signal is active from T+1 through T+A.
  - It is inactive from T+A+1 through T+A+I, and the next pulse starts at T+A+I+1.
- Burst end: the last pulse ends at edge E = T + N·A + (N−1)·I. At E+1 the line is inactive, busy = 0, done = 1 and pulse_cnt = N, all in the same cycle. done is 0 again at E+2.
- Back-to-back bursts: a start presented in the first IDLE cycle (the same cycle done is high) is accepted. Minimum spacing is one inactive cycle between bursts.
- Abort: stop sampled at edge S gives an inactive line and busy = 0 at S+1.
- Reset asserted mid-burst: all outputs return to their reset values immediately (asynchronous). The line goes to ~output_valid_level without waiting for a clock.

## Test plan
- Basic burst: level=1, A=3, I=2, N=2, start at cycle 10 -> line high 11–13, low 14–15, high 16–18; busy high 11–18; done=1, busy=0, pulse_cnt=2 at 19.
- Low-active single pulse: level=0, A=1, I=5, N=1 -> line 0 for exactly one cycle; done one cycle later; the line idles at 1.
- Zero handling: A=0, I=0, N=3 -> pulses of 1 clock separated by 1 clock; done at start+6. Separately, N=0 -> done pulse at start+1, busy never set, line never active.
- Abort: A=10, I=10, N=5, stop in the 4th cycle of pulse 2 -> line inactive and busy=0 next cycle; done never asserted; pulse_cnt=1. Separately, start and stop together in IDLE -> no activity.
- Ignored inputs: start pulses during busy, and active_clk changed mid-burst -> waveform identical to the undisturbed run.
- Level and reset: toggle output_valid_level while idle -> line follows one cycle later. Assert sys_rst_n low mid-pulse -> line, busy, done and pulse_cnt reach their reset values asynchronously; after release, a new start runs normally.
